// File: rtl/shift_amt_gen_mc.sv
// Per-channel shift-amount generator: a fixed-latency chunked leading-zero scanner
// fills a per-channel lz table; registered queries return the datapath shift amounts.
module shift_amt_gen_mc #(
   parameter int unsigned N_MAX         = 128,
   parameter int unsigned NUM_CH        = 4,
   parameter int unsigned WIDTH_MAC_IN  = 48,
   parameter int unsigned FRAC_BITS_IN  = 16,
   parameter int unsigned SCAN_BITS     = 8,
   parameter int unsigned MAX_SHIFT_RA1 = 14,
   parameter int unsigned MAX_SHIFT_RA2 = 45,
   parameter int unsigned MAX_SHIFT_L   = 46,
   localparam int unsigned CFG_W = $clog2(N_MAX + 1),
   localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int unsigned RA1_W = $clog2(MAX_SHIFT_RA1 + 1),
   localparam int unsigned RA2_W = $clog2(MAX_SHIFT_RA2 + 1),
   localparam int unsigned L_W   = $clog2(MAX_SHIFT_L + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    cfg_load,
   input  logic [CFG_W-1:0]        cfg_n,
   output logic                    cfg_err,
   input  logic                    var_valid,
   output logic                    var_ready,
   input  logic [CH_W-1:0]         var_ch,
   input  logic [WIDTH_MAC_IN-1:0] var_data,
   input  logic                    ch_clr,
   input  logic                    en,
   input  logic [2:0]              state,
   input  logic [1:0]              l_count,
   input  logic [CH_W-1:0]         q_ch,
   output logic [RA1_W-1:0]        shift_ra1_amt,
   output logic [RA2_W-1:0]        shift_ra2_amt,
   output logic [L_W-1:0]          shift_l_amt,
   output logic                    q_miss,
   output logic                    l_sat
);
   localparam int unsigned SCAN_CYC = (WIDTH_MAC_IN + SCAN_BITS - 1) / SCAN_BITS;
   localparam int unsigned PAD_W    = SCAN_CYC * SCAN_BITS;
   localparam int unsigned LZ_W     = $clog2(WIDTH_MAC_IN + 1);
   localparam int unsigned ACC_W    = $clog2(PAD_W + 1);
   localparam int unsigned SB_W     = $clog2(SCAN_BITS + 1);
   localparam int unsigned CYC_W    = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
   localparam int unsigned LOG_W    = (CFG_W > 1) ? $clog2(CFG_W) : 1;
   localparam int unsigned CHX_W    = CH_W + 1;
   localparam int unsigned SH_IN    = WIDTH_MAC_IN - 2;
   localparam int unsigned SH_OUT   = (2 * WIDTH_MAC_IN - 3 * FRAC_BITS_IN - 6) >> 1;

   typedef enum logic [1:0] {IDLE, SCAN, WRITE} fsm_t;

   fsm_t                  fsm_q, fsm_d;
   logic                  take_c;
   logic [PAD_W-1:0]      sreg;
   logic [CH_W-1:0]       wr_ch;
   logic [ACC_W-1:0]      acc;
   logic                  found;
   logic [CYC_W-1:0]      cyc;
   logic [SCAN_BITS-1:0]  chunk_c;
   logic [SB_W-1:0]       chunk_lz_c;
   logic [LZ_W-1:0]       lz_fin_c;
   logic                  wr_ok_c;
   logic [LZ_W-1:0]       lz_tab [NUM_CH];
   logic [NUM_CH-1:0]     tab_vld;
   logic [LOG_W-1:0]      log2n;
   logic [LOG_W-1:0]      log2_c;
   logic                  cfg_err_c;
   logic                  q_hit_c;
   logic [LZ_W-1:0]       lz_q_c;
   logic [RA2_W-1:0]      ra2_c;
   logic [L_W-1:0]        sl_c;
   logic                  sat_c;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) fsm_q <= IDLE;
      else        fsm_q <= fsm_d;
   end

   always_comb begin
      fsm_d  = fsm_q;
      take_c = 1'b0;
      case (fsm_q)
         IDLE: if (var_valid && var_ready) begin
            take_c = 1'b1;
            fsm_d  = SCAN;
         end
         SCAN:    if (cyc == CYC_W'(SCAN_CYC - 1)) fsm_d = WRITE;
         WRITE:   fsm_d = IDLE;
         default: fsm_d = IDLE;
      endcase
   end

   // Leading zeros of the current MSB-side chunk; the last hit is the highest set bit.
   always_comb begin
      chunk_c    = sreg[PAD_W-1 -: SCAN_BITS];
      chunk_lz_c = SB_W'(SCAN_BITS);
      for (int i = 0; i < int'(SCAN_BITS); i++) begin
         if (chunk_c[i]) chunk_lz_c = SB_W'(int'(SCAN_BITS) - 1 - i);
      end
   end

   // LSB zero padding only inflates the all-zero case, so clamp to the word width.
   always_comb begin
      lz_fin_c = (acc > ACC_W'(WIDTH_MAC_IN)) ? LZ_W'(WIDTH_MAC_IN) : LZ_W'(acc);
      wr_ok_c  = (CHX_W'(wr_ch) < CHX_W'(NUM_CH));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sreg      <= '0;
         wr_ch     <= '0;
         acc       <= '0;
         found     <= 1'b0;
         cyc       <= '0;
         var_ready <= 1'b0;
      end else begin
         var_ready <= (fsm_d == IDLE);
         if (take_c) begin
            sreg  <= PAD_W'(var_data) << (PAD_W - WIDTH_MAC_IN);
            wr_ch <= var_ch;
            acc   <= '0;
            found <= 1'b0;
            cyc   <= '0;
         end else if (fsm_q == SCAN) begin
            sreg <= sreg << SCAN_BITS;
            cyc  <= cyc + CYC_W'(1);
            if (!found) begin
               acc <= acc + ACC_W'(chunk_lz_c);
               if (chunk_c != '0) found <= 1'b1;
            end
         end
      end
   end

   // Table update; a write lands after a same-cycle clear so the written channel stays valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_CH); i++) lz_tab[i] <= '0;
         tab_vld <= '0;
      end else begin
         if (ch_clr) tab_vld <= '0;
         if (fsm_q == WRITE && wr_ok_c) begin
            lz_tab[wr_ch]  <= lz_fin_c;
            tab_vld[wr_ch] <= 1'b1;
         end
      end
   end

   always_comb begin
      log2_c = '0;
      for (int i = 0; i < int'(CFG_W); i++) begin
         if (cfg_n[i]) log2_c = LOG_W'(i);
      end
      cfg_err_c = (cfg_n == '0) || ((cfg_n & (cfg_n - CFG_W'(1))) != '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         log2n   <= '0;
         cfg_err <= 1'b0;
      end else if (cfg_load) begin
         log2n   <= log2_c;
         cfg_err <= cfg_err_c;
      end
   end

   always_comb begin
      q_hit_c = (CHX_W'(q_ch) < CHX_W'(NUM_CH)) && tab_vld[q_ch];
      lz_q_c  = q_hit_c ? lz_tab[q_ch] : '0;
      ra2_c   = '0;
      if (state[1:0] == l_count) begin
         if (state == 3'b010)      ra2_c = RA2_W'({log2n, 1'b0});
         else if (state == 3'b011) ra2_c = RA2_W'(SH_OUT) + RA2_W'(lz_q_c >> 1);
      end
      if (lz_q_c <= LZ_W'(SH_IN)) begin
         sl_c  = L_W'(LZ_W'(SH_IN) - lz_q_c);
         sat_c = 1'b0;
      end else begin
         sl_c  = '0;
         sat_c = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_ra1_amt <= '0;
         shift_ra2_amt <= '0;
         shift_l_amt   <= '0;
         q_miss        <= 1'b0;
         l_sat         <= 1'b0;
      end else if (en) begin
         shift_ra1_amt <= RA1_W'({log2n, 1'b0});
         shift_ra2_amt <= ra2_c;
         shift_l_amt   <= sl_c;
         q_miss        <= !q_hit_c;
         l_sat         <= sat_c;
      end
   end
endmodule

// File: tb/tb_shift_amt_gen_mc.sv
// Directed bench for shift_amt_gen_mc: a vector table of scans plus queries, then
// hand-written sequences for config, read-before-write, clear and mid-scan reset.
module tb_shift_amt_gen_mc;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_load;
   logic [7:0]  cfg_n;
   logic        cfg_err;
   logic        var_valid;
   logic        var_ready;
   logic [1:0]  var_ch;
   logic [47:0] var_data;
   logic        ch_clr;
   logic        en;
   logic [2:0]  state;
   logic [1:0]  l_count;
   logic [1:0]  q_ch;
   logic [3:0]  shift_ra1_amt;
   logic [5:0]  shift_ra2_amt;
   logic [5:0]  shift_l_amt;
   logic        q_miss;
   logic        l_sat;

   int errors = 0;
   int checks = 0;

   shift_amt_gen_mc dut (
      .clk(clk), .rst_n(rst_n), .cfg_load(cfg_load), .cfg_n(cfg_n), .cfg_err(cfg_err),
      .var_valid(var_valid), .var_ready(var_ready), .var_ch(var_ch), .var_data(var_data),
      .ch_clr(ch_clr), .en(en), .state(state), .l_count(l_count), .q_ch(q_ch),
      .shift_ra1_amt(shift_ra1_amt), .shift_ra2_amt(shift_ra2_amt),
      .shift_l_amt(shift_l_amt), .q_miss(q_miss), .l_sat(l_sat)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] data;
      logic [1:0]  ch;
      logic [2:0]  st;
      logic [1:0]  lc;
      int          ra2;
      int          sl;
      bit          sat;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!var_ready && n < 100) begin
         tick();
         n++;
      end
      if (!var_ready) begin
         errors++;
         checks++;
         $display("FAIL ready_timeout: got var_ready=0 expected 1 within 100 cycles");
      end
   endtask

   task automatic scan_start(input logic [1:0] ch, input logic [47:0] data);
      int n;
      wait_ready(n);
      var_valid = 1'b1;
      var_ch    = ch;
      var_data  = data;
      tick();
      var_valid = 1'b0;
   endtask

   task automatic scan(input logic [1:0] ch, input logic [47:0] data, output int low);
      scan_start(ch, data);
      wait_ready(low);
   endtask

   task automatic query(input logic [1:0] ch, input logic [2:0] st, input logic [1:0] lc);
      en = 1'b1; q_ch = ch; state = st; l_count = lc;
      tick();
      en = 1'b0;
   endtask

   task automatic load_cfg(input logic [7:0] n);
      cfg_load = 1'b1; cfg_n = n;
      tick();
      cfg_load = 1'b0;
   endtask

   initial begin
      int low;
      vecs[0] = '{48'h0000_0001_0000, 2'd1, 3'b011, 2'd3, 36, 15, 1'b0};
      vecs[1] = '{48'h0000_0000_0001, 2'd2, 3'b011, 2'd3, 44,  0, 1'b1};
      vecs[2] = '{48'h0000_0000_0000, 2'd2, 3'b011, 2'd3, 45,  0, 1'b1};
      vecs[3] = '{48'h8000_0000_0000, 2'd3, 3'b011, 2'd3, 21, 46, 1'b0};
      vecs[4] = '{48'h0000_00FF_0000, 2'd0, 3'b010, 2'd2, 12, 22, 1'b0};
      vecs[5] = '{48'h0001_0000_0000, 2'd1, 3'b011, 2'd2,  0, 31, 1'b0};
      vecs[6] = '{48'h0000_0000_0080, 2'd3, 3'b000, 2'd0,  0,  6, 1'b0};
      vecs[7] = '{48'h00F0_0000_0000, 2'd0, 3'b111, 2'd3,  0, 38, 1'b0};

      rst_n = 1'b0; cfg_load = 1'b0; cfg_n = '0; var_valid = 1'b0; var_ch = '0;
      var_data = '0; ch_clr = 1'b0; en = 1'b0; state = '0; l_count = '0; q_ch = '0;
      tick(); tick();
      chk("rst_ra1", int'(shift_ra1_amt), 0);
      chk("rst_l", int'(shift_l_amt), 0);
      chk("rst_ready", int'(var_ready), 0);
      rst_n = 1'b1;
      tick();
      chk("ready_after_rst", int'(var_ready), 1);

      // Test 1: config N=64, query empty channel 0
      load_cfg(8'd64);
      chk("cfg64_err", int'(cfg_err), 0);
      query(2'd0, 3'b000, 2'd0);
      chk("t1_ra1", int'(shift_ra1_amt), 12);
      chk("t1_miss", int'(q_miss), 1);
      chk("t1_l", int'(shift_l_amt), 46);

      // Test 2: ready-low duration of one scan
      scan(2'd1, 48'h0000_0001_0000, low);
      chk("scan_busy_cycles", low, 7);

      // Vector table: scan then query
      for (int i = 0; i < 8; i++) begin
         scan(vecs[i].ch, vecs[i].data, low);
         query(vecs[i].ch, vecs[i].st, vecs[i].lc);
         chk($sformatf("v%0d_ra1", i), int'(shift_ra1_amt), 12);
         chk($sformatf("v%0d_ra2", i), int'(shift_ra2_amt), vecs[i].ra2);
         chk($sformatf("v%0d_l", i), int'(shift_l_amt), vecs[i].sl);
         chk($sformatf("v%0d_sat", i), int'(l_sat), int'(vecs[i].sat));
         chk($sformatf("v%0d_miss", i), int'(q_miss), 0);
      end

      // Outputs hold while en=0
      q_ch = 2'd3; state = 3'b011; l_count = 2'd3;
      tick();
      chk("hold_l", int'(shift_l_amt), 38);
      chk("hold_ra2", int'(shift_ra2_amt), 0);

      // Test 4: non-power-of-two and boundary config values
      load_cfg(8'd100);
      chk("cfg100_err", int'(cfg_err), 1);
      query(2'd0, 3'b010, 2'd2);
      chk("cfg100_ra2_match", int'(shift_ra2_amt), 12);
      chk("cfg100_ra1", int'(shift_ra1_amt), 12);
      query(2'd0, 3'b010, 2'd1);
      chk("cfg100_ra2_nomatch", int'(shift_ra2_amt), 0);
      load_cfg(8'd0);
      chk("cfg0_err", int'(cfg_err), 1);
      query(2'd0, 3'b010, 2'd2);
      chk("cfg0_ra1", int'(shift_ra1_amt), 0);
      load_cfg(8'd128);
      chk("cfg128_err", int'(cfg_err), 0);
      query(2'd0, 3'b010, 2'd2);
      chk("cfg128_ra1", int'(shift_ra1_amt), 14);
      chk("cfg128_ra2", int'(shift_ra2_amt), 14);
      load_cfg(8'd64);

      // Test 5a: read-before-write on ch1 (old lz=15, new lz=31)
      scan_start(2'd1, 48'h0000_0000_0001_0000);
      for (int i = 0; i < 6; i++) tick();
      query(2'd1, 3'b000, 2'd0);
      chk("rbw_old_l", int'(shift_l_amt), 31);
      chk("rbw_ready", int'(var_ready), 1);
      query(2'd1, 3'b000, 2'd0);
      chk("rbw_new_l", int'(shift_l_amt), 15);

      // Test 5b: clear all valid bits
      ch_clr = 1'b1;
      tick();
      ch_clr = 1'b0;
      query(2'd1, 3'b000, 2'd0);
      chk("clr_miss", int'(q_miss), 1);
      chk("clr_l", int'(shift_l_amt), 46);

      // Test 5c: clear coinciding with WRITE; old valid seen that cycle, write wins
      scan_start(2'd2, 48'h0000_0000_0080);
      for (int i = 0; i < 6; i++) tick();
      ch_clr = 1'b1;
      query(2'd2, 3'b000, 2'd0);
      ch_clr = 1'b0;
      chk("clrw_old_miss", int'(q_miss), 1);
      query(2'd2, 3'b000, 2'd0);
      chk("clrw_new_miss", int'(q_miss), 0);
      chk("clrw_new_l", int'(shift_l_amt), 6);
      query(2'd3, 3'b000, 2'd0);
      chk("clrw_other_miss", int'(q_miss), 1);

      // Test 6: reset in the middle of a scan
      scan(2'd3, 48'h0000_0000_0080, low);
      query(2'd3, 3'b000, 2'd0);
      chk("pre_rst_l", int'(shift_l_amt), 6);
      scan_start(2'd3, 48'h8000_0000_0000);
      tick(); tick();
      rst_n = 1'b0;
      #1;
      chk("midrst_l", int'(shift_l_amt), 0);
      chk("midrst_ra1", int'(shift_ra1_amt), 0);
      chk("midrst_ready", int'(var_ready), 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("postrst_ready", int'(var_ready), 1);
      for (int i = 0; i < 8; i++) tick();
      query(2'd3, 3'b011, 2'd3);
      chk("postrst_miss", int'(q_miss), 1);
      chk("postrst_ra1", int'(shift_ra1_amt), 0);
      scan(2'd3, 48'h0000_0001_0000, low);
      chk("postrst_busy", low, 7);
      query(2'd3, 3'b011, 2'd3);
      chk("postrst_scan_miss", int'(q_miss), 0);
      chk("postrst_scan_l", int'(shift_l_amt), 15);
      chk("postrst_scan_ra2", int'(shift_ra2_amt), 36);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
